lab_ms_sv4_issuer: RTL
======================

Name: lab_ms_sv4_issuer

Overview:
- Sequential front-end for the combinational lab_MS_SV4 ALU.
- Accepts instruction words from an upstream producer over a valid/ready handshake and buffers them in a small FIFO.
- Issues one instruction at a time on the ALU's INST input and captures the ALU's ALU_out result.
- Returns each result downstream over a second valid/ready handshake, with an error flag and a sequence tag.

Parameters:
- DEPTH, 4, command FIFO depth in entries; power of two, at least 2.
- TAG_W, 4, width of the result sequence tag.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- cmd_valid  input  1  upstream offers cmd_inst.
- cmd_ready  output  1  block can accept a command this cycle.
- cmd_inst  input  INST_t (lab_MS_SV4_pack)  instruction: opc, op_a, op_b.
- INST  output  INST_t  instruction driven to the ALU.
- ALU_out  input  data_y  result returned combinationally by the ALU.
- res_valid  output  1  result registers hold an unconsumed result.
- res_ready  input  1  downstream accepts the result.
- res_data  output  data_y  captured result.
- res_err  output  1  result is invalid: divide/modulo by zero, or illegal opc.
- res_tag  output  TAG_W  sequence number of the result.
- fifo_level  output  $clog2(DEPTH)+1  number of buffered commands.

Behaviour:
- Reset (rst=1 at a rising edge):
  - FIFO flushed; fifo_level=0; cmd_ready=1 from the following cycle.
  - FSM goes to IDLE; res_valid=0, res_data=0, res_err=0, res_tag=0.
  - A result pending at reset is discarded. Reset overrides every simultaneous push, pop or handshake.
- Push:
  - cmd_ready = (fifo_level < DEPTH), combinational from registered state only. There is no bypass: a pop in the same cycle does not raise cmd_ready while the FIFO is full.
  - The FIFO is written when cmd_valid && cmd_ready at the edge.
  - Pointers wrap modulo DEPTH; order is strict FIFO.
- INST output:
  - Equals the FIFO head when fifo_level>0, else all zeros.
  - The ALU value is only sampled in ISSUE.
- FSM states:
  - IDLE: if fifo_level>0, go to ISSUE.
  - ISSUE (exactly one cycle), at the edge:
    - res_data <= ALU_out, except forced to 0 when (opc==DIV or opc==VAR) and op_b==0.
    - res_err <= 1 for zero divisor, or for opc not in {ADD, SUB, MUL, DIV, VAR}; else 0.
    - Pop the head; res_valid <= 1; go to RESP.
  - RESP:
    - res_data, res_err and res_tag are held stable while res_valid=1 && !res_ready.
    - On res_valid && res_ready: res_valid <= 0 and res_tag <= res_tag+1 (wraps 2^TAG_W-1 -> 0).
    - After the handshake, go to ISSUE if the FIFO is non-empty, else IDLE.
    - The FIFO non-empty test counts a push landing in the same cycle. That push's data is the head next cycle only if the FIFO was otherwise empty.
- Arithmetic: entirely inside the ALU. Results are not extended or truncated; res_data has the data_y width.
- Latency:
  - Command accepted at edge E0 with the block idle and FIFO empty: IDLE->ISSUE at E1, res_valid=1 after E2.
  - Back-to-back results with res_ready tied high: one per 2 cycles (ISSUE, RESP alternate).
- Simultaneous push and pop (ISSUE cycle, not full): fifo_level unchanged.
- Backpressure: with res_ready low, the FIFO fills to DEPTH, then cmd_ready=0. No command is dropped or reordered.

Test Plan:
- Reset then push {ADD, 5, 3} with res_ready=1 -> res_valid high 2 cycles after acceptance; res_data=8, res_err=0, res_tag=0.
- Push SUB 9,4; MUL 6,7; VAR 17,5 back-to-back, res_ready=1 -> results 5, 42, 2 in order with tags 0,1,2, one every 2 cycles.
- Push {DIV, 10, 0} then {ADD, 1, 1} -> first result res_data=0, res_err=1; second res_data=2, res_err=0.
- res_ready=0, push DEPTH+2 commands -> one held in result regs, fifo_level reaches 4, cmd_ready=0. Releasing res_ready drains all in order with no loss.
- Push 18 ADD commands -> res_tag runs 0..15, 0, 1 (wraps).
- Assert rst while res_valid=1 and fifo_level=3 -> next cycle res_valid=0, fifo_level=0, res_tag=0; a fresh ADD 2,2 returns 4 with tag 0.

Source files
------------

// File: rtl/lab_MS_SV4_pack.sv
// Shared types for the lab_MS_SV4 ALU and its issuer: operand/result widths,
// opcode encoding and the packed instruction word.
package lab_MS_SV4_pack;
  localparam int DATA_W = 8;

  typedef logic [DATA_W-1:0]   data_x;
  typedef logic [2*DATA_W-1:0] data_y;

  // Codes 5..7 are unassigned and treated as illegal by consumers.
  typedef enum logic [2:0] {
    ADD = 3'd0,
    SUB = 3'd1,
    MUL = 3'd2,
    DIV = 3'd3,
    VAR = 3'd4
  } opc_t;

  typedef struct packed {
    opc_t  opc;
    data_x op_a;
    data_x op_b;
  } INST_t;
endpackage

// File: rtl/lab_ms_sv4_issuer.sv
// Sequential front-end for the combinational lab_MS_SV4 ALU: buffers commands in a
// FIFO, issues them one at a time and returns tagged results over valid/ready.
module lab_ms_sv4_issuer
  import lab_MS_SV4_pack::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  INST_t                    cmd_inst,
  output INST_t                    INST,
  input  data_y                    ALU_out,
  output logic                     res_valid,
  input  logic                     res_ready,
  output data_y                    res_data,
  output logic                     res_err,
  output logic [TAG_W-1:0]         res_tag,
  output logic [$clog2(DEPTH):0]   fifo_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RESP} state_t;

  INST_t             r_mem [DEPTH];
  logic [AW-1:0]     r_wptr;
  logic [AW-1:0]     r_rptr;
  logic [LW-1:0]     r_level;
  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_res_valid;
  data_y             r_res_data;
  logic              r_res_err;
  logic [TAG_W-1:0]  r_res_tag;
  logic              w_push;
  logic              w_pop;
  logic              w_hs;
  logic              w_nonempty;

  function automatic logic f_zero_div(input INST_t i);
    return ((i.opc == DIV) || (i.opc == VAR)) && (i.op_b == '0);
  endfunction

  function automatic logic f_bad_opc(input opc_t o);
    logic bad;
    case (o)
      ADD, SUB, MUL, DIV, VAR: bad = 1'b0;
      default:                 bad = 1'b1;
    endcase
    return bad;
  endfunction

  assign w_nonempty = (r_level != '0);
  assign cmd_ready  = (r_level < LW'(DEPTH));
  assign w_push     = cmd_valid && cmd_ready;
  assign w_pop      = (r_state == S_ISSUE);
  assign w_hs       = r_res_valid && res_ready;
  assign INST       = w_nonempty ? r_mem[r_rptr] : '0;

  assign res_valid  = r_res_valid;
  assign res_data   = r_res_data;
  assign res_err    = r_res_err;
  assign res_tag    = r_res_tag;
  assign fifo_level = r_level;

  // Storage is data only; occupancy is tracked by the pointers and level.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= cmd_inst;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // A push landing on the handshake edge counts toward the non-empty test.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_nonempty) w_state_nxt = S_ISSUE;
      S_ISSUE: w_state_nxt = S_RESP;
      S_RESP:  if (w_hs) w_state_nxt = (w_nonempty || w_push) ? S_ISSUE : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
      r_res_err   <= 1'b0;
      r_res_tag   <= '0;
    end else if (r_state == S_ISSUE) begin
      r_res_data  <= f_zero_div(INST) ? '0 : ALU_out;
      r_res_err   <= f_zero_div(INST) || f_bad_opc(INST.opc);
      r_res_valid <= 1'b1;
    end else if (w_hs) begin
      r_res_valid <= 1'b0;
      r_res_tag   <= r_res_tag + TAG_W'(1);
    end
  end

endmodule
